// File: rtl/ob_cntrl_mk_arb.sv
// Market-order trade arbiter: picks one of LB_MS / LS_MB / MS_MB from the table heads
// and presents it on a valid/ready handshake. FSM: IDLE = accepting queries | HOLD = trade presented.
module ob_cntrl_mk_arb #(
  parameter int QTY_W      = 16,
  parameter int PRICE_W    = 20,
  parameter int UID_W      = 32,
  parameter int PRIO_MODE  = 0,
  parameter int STARVE_MAX = 4,
  localparam int ORD_W     = UID_W + PRICE_W + QTY_W,
  localparam int SIDE_W    = UID_W + PRICE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lm_bid_vld,
  input  logic [ORD_W-1:0]  lm_bid,
  input  logic              lm_ask_vld,
  input  logic [ORD_W-1:0]  lm_ask,
  input  logic              mk_bid_vld,
  input  logic [ORD_W-1:0]  mk_bid,
  input  logic              mk_ask_vld,
  input  logic [ORD_W-1:0]  mk_ask,
  input  logic              trade_qry,
  output logic              qry_rdy,
  output logic              trade_none,
  output logic              trade_vld,
  input  logic              trade_rdy,
  output logic [2:0]        trade_kind,
  output logic [SIDE_W-1:0] trade_ask,
  output logic [SIDE_W-1:0] trade_bid,
  output logic [1:0]        trade_cons,
  output logic [QTY_W-1:0]  trade_qty,
  output logic [QTY_W-1:0]  trade_rem,
  output logic [31:0]       trade_cnt
);

  localparam int SC_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SC_W-1:0] SC_LIM = SC_W'(STARVE_MAX);

  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nxt;

  logic [2:0]        elig;
  logic              gnt_any, accept, hs, starve_hit, ms_elig_q;
  logic [1:0]        gnt, gnt_q, rr_ptr;
  logic [SC_W-1:0]   starve_cnt;
  logic [ORD_W-1:0]  ask_ord, bid_ord;
  logic [QTY_W-1:0]  ask_q, bid_q, qty_nxt, rem_nxt;
  logic [2:0]        kind_nxt;
  logic [1:0]        cons_nxt;
  logic [SIDE_W-1:0] ask_side, bid_side;

  function automatic logic usable(input logic vld, input logic [ORD_W-1:0] ord);
    return vld && (ord[QTY_W-1:0] != '0);
  endfunction

  assign elig = {usable(mk_bid_vld, mk_bid) && usable(mk_ask_vld, mk_ask),
                 usable(lm_ask_vld, lm_ask) && usable(mk_bid_vld, mk_bid),
                 usable(lm_bid_vld, lm_bid) && usable(mk_ask_vld, mk_ask)};
  assign gnt_any    = |elig;
  assign starve_hit = (STARVE_MAX != 0) && (starve_cnt == SC_LIM);

  always_comb begin
    gnt = 2'd0;
    if (PRIO_MODE != 0) begin
      case (rr_ptr)
        2'd1:    gnt = elig[1] ? 2'd1 : (elig[2] ? 2'd2 : 2'd0);
        2'd2:    gnt = elig[2] ? 2'd2 : (elig[0] ? 2'd0 : 2'd1);
        default: gnt = elig[0] ? 2'd0 : (elig[1] ? 2'd1 : 2'd2);
      endcase
    end else if (starve_hit && elig[2]) begin
      gnt = 2'd2;
    end else begin
      gnt = elig[0] ? 2'd0 : (elig[1] ? 2'd1 : 2'd2);
    end
  end

  always_comb begin
    ask_ord  = mk_ask;
    bid_ord  = lm_bid;
    kind_nxt = 3'b001;
    case (gnt)
      2'd1: begin
        ask_ord  = lm_ask;
        bid_ord  = mk_bid;
        kind_nxt = 3'b010;
      end
      2'd2: begin
        ask_ord  = mk_ask;
        bid_ord  = mk_bid;
        kind_nxt = 3'b100;
      end
      default: ;
    endcase
    ask_q    = ask_ord[QTY_W-1:0];
    bid_q    = bid_ord[QTY_W-1:0];
    ask_side = ask_ord[ORD_W-1:QTY_W];
    // Market-vs-market trades clear at the market ask price on both sides.
    bid_side = {bid_ord[ORD_W-1 -: UID_W],
                (gnt == 2'd2) ? mk_ask[QTY_W +: PRICE_W] : bid_ord[QTY_W +: PRICE_W]};
    qty_nxt  = (ask_q < bid_q) ? ask_q : bid_q;
    rem_nxt  = (ask_q < bid_q) ? (bid_q - ask_q) : (ask_q - bid_q);
    cons_nxt = {ask_q <= bid_q, bid_q <= ask_q};
  end

  always_comb begin
    state_nxt = state;
    accept    = (state == IDLE) && trade_qry;
    hs        = (state == HOLD) && trade_rdy;
    case (state)
      IDLE:    if (accept && gnt_any) state_nxt = HOLD;
      HOLD:    if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign qry_rdy   = (state == IDLE);
  assign trade_vld = (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trade_none <= 1'b0;
      trade_kind <= '0;
      trade_ask  <= '0;
      trade_bid  <= '0;
      trade_cons <= '0;
      trade_qty  <= '0;
      trade_rem  <= '0;
      trade_cnt  <= '0;
      gnt_q      <= '0;
      ms_elig_q  <= 1'b0;
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      trade_none <= accept && !gnt_any;
      if (accept && gnt_any) begin
        trade_kind <= kind_nxt;
        trade_ask  <= ask_side;
        trade_bid  <= bid_side;
        trade_cons <= cons_nxt;
        trade_qty  <= qty_nxt;
        trade_rem  <= rem_nxt;
        gnt_q      <= gnt;
        ms_elig_q  <= elig[2];
      end
      if (hs) begin
        trade_cnt <= trade_cnt + 32'd1;
        rr_ptr    <= (gnt_q == 2'd2) ? 2'd0 : gnt_q + 2'd1;
        // Bypass counting only matters in fixed-priority mode.
        if (PRIO_MODE == 0 && STARVE_MAX != 0 && ms_elig_q && gnt_q != 2'd2)
          starve_cnt <= starve_hit ? starve_cnt : starve_cnt + SC_W'(1);
        else
          starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ob_cntrl_mk_arb.sv
// Bench for ob_cntrl_mk_arb: three instances (fixed/STARVE 4, fixed/STARVE 2, round-robin)
// share stimulus and are compared every cycle against a transaction-level model.
module tb_ob_cntrl_mk_arb;
  localparam int QW = 16, PW = 20, UW = 32, OW = QW + PW + UW, SW = UW + PW, N = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic lbv = 0, lav = 0, mbv = 0, mav = 0, trade_qry = 0, trade_rdy = 0;
  logic [OW-1:0] lb = '0, la = '0, mb = '0, ma = '0;

  logic          qry_rdy_a[N], none_a[N], vld_a[N];
  logic [2:0]    kind_a[N];
  logic [SW-1:0] ask_a[N], bid_a[N];
  logic [1:0]    cons_a[N];
  logic [QW-1:0] qty_a[N], rem_a[N];
  logic [31:0]   cnt_a[N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    ob_cntrl_mk_arb #(.QTY_W(QW), .PRICE_W(PW), .UID_W(UW),
                      .PRIO_MODE((g == 2) ? 1 : 0), .STARVE_MAX((g == 1) ? 2 : 4)) dut (
      .clk(clk), .rst(rst),
      .lm_bid_vld(lbv), .lm_bid(lb), .lm_ask_vld(lav), .lm_ask(la),
      .mk_bid_vld(mbv), .mk_bid(mb), .mk_ask_vld(mav), .mk_ask(ma),
      .trade_qry(trade_qry), .qry_rdy(qry_rdy_a[g]), .trade_none(none_a[g]),
      .trade_vld(vld_a[g]), .trade_rdy(trade_rdy), .trade_kind(kind_a[g]),
      .trade_ask(ask_a[g]), .trade_bid(bid_a[g]), .trade_cons(cons_a[g]),
      .trade_qty(qty_a[g]), .trade_rem(rem_a[g]), .trade_cnt(cnt_a[g]));
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, idx, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0]    kind;
    logic [SW-1:0] ask, bid;
    logic [1:0]    cons;
    logic [QW-1:0] qty, rem;
  } trade_t;

  int          p_mode[N] = '{0, 0, 1};
  int          p_smax[N] = '{4, 2, 4};
  bit          m_busy[N] = '{0, 0, 0};
  bit          m_none[N] = '{0, 0, 0};
  bit          m_mse[N]  = '{0, 0, 0};
  int          m_rr[N]   = '{0, 0, 0};
  int          m_st[N]   = '{0, 0, 0};
  int          m_gnt[N]  = '{0, 0, 0};
  logic [31:0] m_cnt[N]  = '{0, 0, 0};
  trade_t      m_tr[N];
  bit [2:0]    m_e;
  int          m_g;

  function automatic bit usable(input logic v, input logic [OW-1:0] o);
    return v && (o[QW-1:0] != '0);
  endfunction

  function automatic int pick(input bit [2:0] e, input int mode, input int smax, input int rr, input int st);
    int order[3];
    if (mode == 1) begin
      for (int k = 0; k < 3; k++) order[k] = (rr + k) % 3;
    end else begin
      if (smax != 0 && st >= smax && e[2]) return 2;
      for (int k = 0; k < 3; k++) order[k] = k;
    end
    for (int k = 0; k < 3; k++) if (e[order[k]]) return order[k];
    return -1;
  endfunction

  function automatic trade_t make(input int g);
    trade_t t;
    logic [OW-1:0] a, b;
    int aq, bq;
    a = (g == 1) ? la : ma;
    b = (g == 0) ? lb : mb;
    aq = int'(a[QW-1:0]);
    bq = int'(b[QW-1:0]);
    t.kind    = '0;
    t.kind[g] = 1'b1;
    t.ask  = a[OW-1:QW];
    t.bid  = {b[OW-1 -: UW], (g == 2) ? ma[QW +: PW] : b[QW +: PW]};
    t.qty  = QW'((aq < bq) ? aq : bq);
    t.rem  = QW'((aq > bq) ? aq - bq : bq - aq);
    t.cons = {aq <= bq, bq <= aq};
    return t;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_busy[i] = 0; m_none[i] = 0; m_mse[i] = 0;
        m_rr[i] = 0; m_st[i] = 0; m_gnt[i] = 0; m_cnt[i] = '0;
      end
    end else begin
      m_e = {usable(mbv, mb) && usable(mav, ma), usable(lav, la) && usable(mbv, mb),
             usable(lbv, lb) && usable(mav, ma)};
      for (int i = 0; i < N; i++) begin
        m_none[i] = 0;
        if (!m_busy[i]) begin
          if (trade_qry) begin
            m_g = pick(m_e, p_mode[i], p_smax[i], m_rr[i], m_st[i]);
            if (m_g < 0) m_none[i] = 1;
            else begin
              m_busy[i] = 1; m_tr[i] = make(m_g); m_gnt[i] = m_g; m_mse[i] = m_e[2];
            end
          end
        end else if (trade_rdy) begin
          m_cnt[i] = m_cnt[i] + 32'd1;
          if (p_mode[i] == 1) m_rr[i] = (m_gnt[i] + 1) % 3;
          else if (m_mse[i] && m_gnt[i] != 2) begin
            if (m_st[i] < p_smax[i]) m_st[i]++;
          end else m_st[i] = 0;
          m_busy[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      chk("qry_rdy", i, 64'(qry_rdy_a[i]), 64'(!m_busy[i]));
      chk("trade_vld", i, 64'(vld_a[i]), 64'(m_busy[i]));
      chk("trade_none", i, 64'(none_a[i]), 64'(m_none[i]));
      chk("trade_cnt", i, 64'(cnt_a[i]), 64'(m_cnt[i]));
      if (m_busy[i]) begin
        chk("trade_kind", i, 64'(kind_a[i]), 64'(m_tr[i].kind));
        chk("trade_ask", i, 64'(ask_a[i]), 64'(m_tr[i].ask));
        chk("trade_bid", i, 64'(bid_a[i]), 64'(m_tr[i].bid));
        chk("trade_cons", i, 64'(cons_a[i]), 64'(m_tr[i].cons));
        chk("trade_qty", i, 64'(qty_a[i]), 64'(m_tr[i].qty));
        chk("trade_rem", i, 64'(rem_a[i]), 64'(m_tr[i].rem));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] ord(input logic [31:0] uid, input logic [31:0] price, input logic [31:0] qty);
    return {uid, price[PW-1:0], qty[QW-1:0]};
  endfunction

  task automatic clear_heads();
    lbv = 0; lav = 0; mbv = 0; mav = 0;
    lb = '0; la = '0; mb = '0; ma = '0;
  endtask

  task automatic all_heads();
    lbv = 1; lb = ord(1, 'h10, 8);
    lav = 1; la = ord(2, 'h20, 6);
    mbv = 1; mb = ord(3, 'h30, 7);
    mav = 1; ma = ord(4, 'h40, 9);
  endtask

  task automatic do_reset();
    rst = 1; trade_qry = 0; trade_rdy = 0;
    step(); step();
    rst = 0;
    step();
  endtask

  task automatic handshake();
    trade_rdy = 1; step(); trade_rdy = 0;
  endtask

  logic [2:0] exp_fix2[4] = '{3'b001, 3'b001, 3'b100, 3'b001};
  logic [2:0] exp_rr[4]   = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    do_reset();
    chk("reset_qry_rdy", 0, 64'(qry_rdy_a[0]), 64'd1);
    chk("reset_vld", 0, 64'(vld_a[0]), 64'd0);
    chk("reset_cnt", 0, 64'(cnt_a[0]), 64'd0);

    // limit bid vs market ask, ask side smaller
    clear_heads();
    lbv = 1; lb = ord(7, 'h100, 10);
    mav = 1; ma = ord(9, 'h120, 4);
    trade_qry = 1; step(); trade_qry = 0;
    chk("t1_vld", 0, 64'(vld_a[0]), 64'd1);
    chk("t1_kind", 0, 64'(kind_a[0]), 64'b001);
    chk("t1_qty", 0, 64'(qty_a[0]), 64'd4);
    chk("t1_rem", 0, 64'(rem_a[0]), 64'd6);
    chk("t1_cons", 0, 64'(cons_a[0]), 64'b10);
    chk("t1_ask", 0, 64'(ask_a[0]), 64'({32'd9, 20'h120}));
    chk("t1_bid", 0, 64'(bid_a[0]), 64'({32'd7, 20'h100}));
    handshake();
    chk("t1_cnt", 0, 64'(cnt_a[0]), 64'd1);

    // market pair only, equal quantities
    do_reset(); clear_heads();
    mbv = 1; mb = ord(3, 'h111, 5);
    mav = 1; ma = ord(4, 'h250, 5);
    trade_qry = 1; step(); trade_qry = 0;
    chk("t2_kind", 0, 64'(kind_a[0]), 64'b100);
    chk("t2_qty", 0, 64'(qty_a[0]), 64'd5);
    chk("t2_rem", 0, 64'(rem_a[0]), 64'd0);
    chk("t2_cons", 0, 64'(cons_a[0]), 64'b11);
    chk("t2_ask", 0, 64'(ask_a[0]), 64'({32'd4, 20'h250}));
    chk("t2_bid", 0, 64'(bid_a[0]), 64'({32'd3, 20'h250}));
    handshake();

    // hold with backpressure; queries and head changes during HOLD are ignored
    do_reset(); all_heads();
    trade_qry = 1; step();
    lb = ord(1, 'h10, 3);
    for (int k = 0; k < 6; k++) begin
      chk("t3_hold_vld", k, 64'(vld_a[0]), 64'd1);
      chk("t3_hold_rdy", k, 64'(qry_rdy_a[0]), 64'd0);
      chk("t3_hold_qty", k, 64'(qty_a[0]), 64'd8);
      chk("t3_hold_cons", k, 64'(cons_a[0]), 64'b01);
      step();
    end
    trade_qry = 0;
    handshake();
    chk("t3_cnt", 0, 64'(cnt_a[0]), 64'd1);
    chk("t3_idle", 0, 64'(qry_rdy_a[0]), 64'd1);

    // starvation (instance 1) and round-robin (instance 2)
    do_reset(); all_heads();
    for (int k = 0; k < 4; k++) begin
      trade_qry = 1; step(); trade_qry = 0;
      chk("t4_fix4_kind", k, 64'(kind_a[0]), 64'b001);
      chk("t4_fix2_kind", k, 64'(kind_a[1]), 64'(exp_fix2[k]));
      chk("t5_rr_kind", k, 64'(kind_a[2]), 64'(exp_rr[k]));
      handshake();
    end

    // zero-quantity head filtered -> none pulse; then reset during HOLD
    do_reset(); clear_heads();
    mbv = 1; mb = ord(5, 'h1, 5);
    mav = 1; ma = ord(6, 'h2, 0);
    trade_qry = 1; step(); trade_qry = 0;
    chk("t6_none", 0, 64'(none_a[0]), 64'd1);
    chk("t6_none_vld", 0, 64'(vld_a[0]), 64'd0);
    step();
    chk("t6_none_pulse", 0, 64'(none_a[0]), 64'd0);
    ma = ord(6, 'h2, 3);
    trade_qry = 1; step(); trade_qry = 0;
    handshake();
    chk("t6_cnt_pre", 0, 64'(cnt_a[0]), 64'd1);
    trade_qry = 1; step(); trade_qry = 0;
    chk("t6_hold", 0, 64'(vld_a[0]), 64'd1);
    #1 rst = 1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("t6_rst_vld", i, 64'(vld_a[i]), 64'd0);
      chk("t6_rst_cnt", i, 64'(cnt_a[i]), 64'd0);
      chk("t6_rst_rdy", i, 64'(qry_rdy_a[i]), 64'd1);
    end
    step(); rst = 0; step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      lbv = ($urandom_range(0, 3) != 0); lb = ord($urandom, $urandom, $urandom_range(0, 6));
      lav = ($urandom_range(0, 3) != 0); la = ord($urandom, $urandom, $urandom_range(0, 6));
      mbv = ($urandom_range(0, 3) != 0); mb = ord($urandom, $urandom, $urandom_range(0, 6));
      mav = ($urandom_range(0, 3) != 0); ma = ord($urandom, $urandom, $urandom_range(0, 6));
      trade_qry = ($urandom_range(0, 2) != 0);
      trade_rdy = ($urandom_range(0, 1) != 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0; trade_qry = 0; trade_rdy = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
